// File: rtl/lcd_num_formatter.sv
// Two-row numeric text builder for a 1602 LCD. Each row is a fixed
// six-character label followed by a right-justified ten-digit decimal field.
// One double-dabble converter is shared: it handles val_A and then val_B,
// one bit per clock. Both rows are then committed together, so the display
// never shows a partly converted line.
module lcd_num_formatter #(
    parameter logic [47:0] PREFIX_A = 48'h20_20_20_20_20_20,
    parameter logic [47:0] PREFIX_B = 48'h20_20_20_20_20_20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [31:0]  val_A,
    input  logic [31:0]  val_B,
    output logic         busy,
    output logic         done,
    output logic [127:0] row_A,
    output logic [127:0] row_B
);

    typedef enum logic [1:0] {IDLE, CONV_A, CONV_B, FMT} state_t;

    localparam logic [79:0] BLANK_FIELD = {10{8'h20}};

    state_t      state_reg, state_next;
    logic [31:0] shreg_reg;
    logic [31:0] val_b_reg;
    logic [39:0] bcd_reg;
    logic [39:0] digits_a_reg;
    logic [39:0] digits_b_reg;
    logic [4:0]  cnt_reg;

    logic [39:0] bcd_adj;
    logic [39:0] bcd_shifted;
    logic        last_bit;

    // Add-3 correction on every BCD nibble that would overflow when doubled.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign bcd_shifted = {bcd_adj[38:0], shreg_reg[31]};
    assign last_bit    = (cnt_reg == 5'd31);

    // Turns ten BCD digits into ASCII and blanks the leading zeros.
    // The units digit is always printed, so a value of 0 shows as "0".
    function automatic logic [79:0] fmt_digits(input logic [39:0] d);
        logic [79:0] f;
        logic        seen;
        f    = BLANK_FIELD;
        seen = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            if (d[i*4 +: 4] != 4'd0 || i == 0) begin
                seen = 1'b1;
            end
            f[i*8 +: 8] = seen ? {4'h3, d[i*4 +: 4]} : 8'h20;
        end
        return f;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start is looked at only in IDLE, so a request
    // that arrives while busy (including in FMT) is dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)    state_next = CONV_A;
            CONV_A:  if (last_bit) state_next = CONV_B;
            CONV_B:  if (last_bit) state_next = FMT;
            FMT:                   state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Converter datapath, digit storage and the row update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_reg    <= '0;
            val_b_reg    <= '0;
            bcd_reg      <= '0;
            digits_a_reg <= '0;
            digits_b_reg <= '0;
            cnt_reg      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            row_A        <= {PREFIX_A, BLANK_FIELD};
            row_B        <= {PREFIX_B, BLANK_FIELD};
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shreg_reg <= val_A;
                        val_b_reg <= val_B;
                        bcd_reg   <= '0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                    end
                end
                CONV_A, CONV_B: begin
                    bcd_reg   <= bcd_shifted;
                    shreg_reg <= {shreg_reg[30:0], 1'b0};
                    cnt_reg   <= cnt_reg + 5'd1;
                    if (last_bit) begin
                        cnt_reg <= '0;
                        if (state_reg == CONV_A) begin
                            // Keep row A's digits, then reuse the converter for B.
                            digits_a_reg <= bcd_shifted;
                            shreg_reg    <= val_b_reg;
                            bcd_reg      <= '0;
                        end else begin
                            digits_b_reg <= bcd_shifted;
                        end
                    end
                end
                FMT: begin
                    row_A <= {PREFIX_A, fmt_digits(digits_a_reg)};
                    row_B <= {PREFIX_B, fmt_digits(digits_b_reg)};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_num_formatter.sv
// Self-checking bench for lcd_num_formatter. A cycle-level acceptance model
// predicts busy/done and pushes the expected rows, computed with integer
// division, into a scoreboard when a start is accepted. A monitor checks the
// outputs on every falling edge and pops the scoreboard on each done.
module tb_lcd_num_formatter;

    localparam logic [47:0] PFX_A = 48'h43_4E_54_3A_20_20;   // "CNT:  "
    localparam logic [47:0] PFX_B = 48'h20_20_20_20_20_20;

    logic         clk;
    logic         reset;
    logic         start;
    logic [31:0]  val_A;
    logic [31:0]  val_B;
    logic         busy;
    logic         done;
    logic [127:0] row_A;
    logic [127:0] row_B;

    int checks = 0;
    int errors = 0;

    logic [255:0] sb[$];
    logic [127:0] cur_a, cur_b;
    int           rem = 0;
    logic         model_done = 1'b0;

    lcd_num_formatter #(.PREFIX_A(PFX_A), .PREFIX_B(PFX_B)) dut (
        .clk(clk), .reset(reset), .start(start), .val_A(val_A), .val_B(val_B),
        .busy(busy), .done(done), .row_A(row_A), .row_B(row_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal text by repeated division, blanks above the top digit.
    function automatic logic [79:0] ref_field(input logic [31:0] v);
        logic [79:0]     f;
        longint unsigned p;
        longint unsigned dg;
        f = '0;
        p = 1;
        for (int i = 0; i < 10; i++) begin
            dg = (longint'(v) / p) % 10;
            f[i*8 +: 8] = (i == 0 || longint'(v) >= p) ? 8'(48 + dg) : 8'h20;
            p = p * 10;
        end
        return f;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Acceptance model: a start seen while idle launches a 65-edge job.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem        = 0;
            model_done = 1'b0;
        end else begin
            model_done = 1'b0;
            if (rem == 0 && start) begin
                rem = 65;
                sb.push_back({PFX_A, ref_field(val_A), PFX_B, ref_field(val_B)});
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) model_done = 1'b1;
            end
        end
    end

    // Monitor: compares handshake outputs and rows each cycle, pops on done.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            cur_a = {PFX_A, {10{8'h20}}};
            cur_b = {PFX_B, {10{8'h20}}};
        end else begin
            chk("busy", {127'd0, busy}, {127'd0, (rem > 0)});
            chk("done", {127'd0, done}, {127'd0, model_done});
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    {cur_a, cur_b} = sb.pop_front();
                end
                $display("done: row_A=\"%s\" row_B=\"%s\"", row_A, row_B);
            end
            chk("row_A", row_A, cur_a);
            chk("row_B", row_B, cur_b);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        val_A = a;
        val_B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [127:0] s;
        reset = 1'b0;
        start = 1'b0;
        val_A = '0;
        val_B = '0;
        cycles(3);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_row_A", row_A, {PFX_A, {10{8'h20}}});
        chk("rst_row_B", row_B, {PFX_B, {10{8'h20}}});
        reset = 1'b1;
        cycles(2);

        // Extremes: zero and the maximum 32-bit value.
        pulse(32'd0, 32'hFFFF_FFFF);
        cycles(70);
        s = "         0";
        chk("zero_field", {48'd0, row_A[79:0]}, {48'd0, s[79:0]});
        s = "4294967295";
        chk("max_field", {48'd0, row_B[79:0]}, {48'd0, s[79:0]});

        // Label plus value; interior zero kept in "10".
        pulse(32'd1234567, 32'd10);
        cycles(70);
        chk("cnt_row", row_A, "CNT:     1234567");
        s = "        10";
        chk("ten_field", {48'd0, row_B[79:0]}, {48'd0, s[79:0]});

        // Input change and a second start during the job must be ignored.
        pulse(32'd5, 32'd7);
        cycles(9);
        val_A = 32'd99;
        cycles(10);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(60);
        s = "         5";
        chk("five_field", {48'd0, row_A[79:0]}, {48'd0, s[79:0]});

        // Start held high: back-to-back jobs every 66 cycles.
        start = 1'b1;
        for (int i = 0; i < 3 * 66 + 10; i++) begin
            val_A = $urandom;
            val_B = $urandom_range(0, 99999);
            cycles(1);
        end
        start = 1'b0;
        cycles(70);

        // Asynchronous reset part way through a job.
        pulse(32'd31337, 32'd42);
        cycles(39);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {127'd0, busy}, 128'd0);
        chk("arst_done", {127'd0, done}, 128'd0);
        chk("arst_row_A", row_A, {PFX_A, {10{8'h20}}});
        chk("arst_row_B", row_B, {PFX_B, {10{8'h20}}});
        cycles(3);
        reset = 1'b1;
        cycles(1);

        // Interior zeros and a single digit.
        pulse(32'd100000, 32'd9);
        cycles(70);
        s = "    100000";
        chk("100000_field", {48'd0, row_A[79:0]}, {48'd0, s[79:0]});
        s = "         9";
        chk("nine_field", {48'd0, row_B[79:0]}, {48'd0, s[79:0]});

        // Randomized jobs with stray start requests while busy.
        for (int n = 0; n < 20; n++) begin
            pulse(($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 999),
                  ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 99));
            for (int c = 0; c < 66 + int'($urandom_range(0, 5)); c++) begin
                start = ($urandom_range(0, 9) == 0);
                val_A = $urandom;
                cycles(1);
            end
            start = 1'b0;
            cycles(70);
        end

        // Drain: every accepted job must have produced its done.
        for (int t = 0; t < 200 && sb.size() != 0; t++) cycles(1);
        chk("sb_empty", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_num_formatter.md
Name: lcd_num_formatter

Overview:
- Builds the two 16-character ASCII rows (row_A, row_B) consumed by the 1602 LCD text controller.
- Converts two 32-bit unsigned values to right-justified decimal text, behind fixed per-row labels.
- Conversion is sequential double-dabble, one bit per clock, sharing a single converter between both rows.
- Rows update atomically, so the LCD refresh never shows a half-converted line.

Parameters:
PREFIX_A, 48'h20_20_20_20_20_20, six ASCII characters placed in row_A[127:80]
PREFIX_B, 48'h20_20_20_20_20_20, six ASCII characters placed in row_B[127:80]

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-low reset
start  input  1  conversion request, sampled only in IDLE
val_A  input  32  unsigned value for row_A, sampled on the accepting edge
val_B  input  32  unsigned value for row_B, sampled on the accepting edge
busy  output  1  high from the accepting edge until done
done  output  1  one-cycle pulse when the new rows are valid
row_A  output  128  {PREFIX_A, 10 ASCII digit chars}, MSB character first
row_B  output  128  {PREFIX_B, 10 ASCII digit chars}

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, busy=0, done=0.
  - row_A = {PREFIX_A, ten 8'h20}; row_B = {PREFIX_B, ten 8'h20}.
  - Internal shift/BCD registers are cleared.
  - A reset asserted mid-conversion discards all work; rows return to their reset values.
- States: IDLE -> CONV_A -> CONV_B -> FMT -> IDLE.
- IDLE, start==1 at an edge (accepting edge E0):
  - latch val_A and val_B; busy<=1; clear the 40-bit BCD register; load the 32-bit shift register with val_A; bit counter = 0.
- CONV_A, one iteration per edge, edges E1..E32:
  - each BCD nibble >= 5 gets +3 (all 10 nibbles in parallel);
  - then {bcd, shreg} is shifted left by 1, bringing shreg[31] into bcd[0];
  - bit counter increments.
  - On E32 the BCD result is stored to digits_A; the shift register is reloaded with the latched val_B and BCD is cleared; state -> CONV_B.
- CONV_B, edges E33..E64: identical iterations. On E64 the result is stored to digits_B; state -> FMT.
- FMT, edge E65:
  - row_A and row_B are written simultaneously; done<=1; busy<=0; state -> IDLE.
  - done is high for exactly the cycle after E65 and deasserts on E66.
- Latency: new rows are visible 65 edges after the accepting edge, with busy high for 65 cycles.
- Digit formatting, per row:
  - digit nibble d maps to 8'h30+d;
  - leading-zero suppression: every digit left of the most significant nonzero digit becomes 8'h20;
  - the least significant digit is always printed, so value 0 gives nine spaces then "0";
  - 10 digits always suffice because the maximum value is 4294967295.
- start while busy==1 is ignored; it is neither queued nor allowed to restart the conversion.
- start high on the same edge that done is asserted (E65) is ignored because the state is still FMT. It is accepted on E66 or later.
- A held start re-triggers each time IDLE is reached, so conversions run back to back every 66 cycles.
- val_A/val_B changes after E0 have no effect on the current conversion.
- row_A/row_B hold their previous contents throughout a conversion; there are no intermediate updates.

Test Plan:
- Reset, then val_A=0, val_B=4294967295, start pulse:
  - busy is high for 65 cycles, then a single done pulse;
  - row_A digit field = "         0";
  - row_B digit field = "4294967295" (hex 34 32 39 34 39 36 37 32 39 35).
- PREFIX_A="CNT:  ", val_A=1234567, val_B=10:
  - row_A = "CNT:     1234567";
  - row_B digit field = "        10" (zero inside the number kept, leading zeros blanked).
- Start accepted with val_A=5; start pulsed again at cycle 20, and val_A changed to 99 at cycle 10:
  - exactly one done;
  - row_A shows "         5";
  - rows unchanged before done.
- start held high continuously:
  - done pulses every 66 cycles;
  - start asserted at the done cycle is not accepted until the following edge.
- Reset asserted at cycle 40 of a conversion:
  - busy, done and the rows return to reset values immediately, without waiting for a clock edge;
  - after release, a new start converts correctly.
- Value 100000 (interior zeros) and value 9 (single digit):
  - fields read "    100000" and "         9".
